delay_scheduler: RTL and testbench

//  Time-shares one programmable delay counter among NUM_REQ requesters.

---
 rtl/blackjack_timer_pkg.sv | 14 +
 rtl/delay_scheduler_rr_picker.sv | 34 +++
 rtl/delay_scheduler.sv | 96 +++++++++
 tb/tb_delay_scheduler.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/blackjack_timer_pkg.sv
// Shared types and defaults for the blackjack timing blocks.
package blackjack_timer_pkg;

  localparam int DEFAULT_WIDTH   = 16;
  localparam int DEFAULT_NUM_REQ = 4;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } sched_state_t;

endpackage

// File: rtl/delay_scheduler_rr_picker.sv
// Combinational round-robin selector: first set request at or above ptr, with wrap.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   index
);

  logic found;
  int   cand;

  // Walk the requests starting at ptr; the first hit wins.
  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    cand  = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = int'(ptr) + off;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        index       = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/delay_scheduler.sv
// Time-shares one down-counter among several delay requesters, round-robin,
// and pulses a one-cycle done back to the requester whose delay expired.
module delay_scheduler
  import blackjack_timer_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int WIDTH   = DEFAULT_WIDTH
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_tick,
  input  logic [NUM_REQ-1:0]       i_req,
  input  logic [NUM_REQ*WIDTH-1:0] i_delay,
  output logic [NUM_REQ-1:0]       o_grant,
  output logic [NUM_REQ-1:0]       o_done,
  output logic                     o_busy,
  output logic [WIDTH-1:0]         o_remaining
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  sched_state_t        state;
  logic [IDX_W-1:0]    rr_ptr;
  logic [IDX_W-1:0]    cur_idx;
  logic [IDX_W-1:0]    next_ptr;
  logic [IDX_W-1:0]    pick_idx;
  logic [NUM_REQ-1:0]  pick_grant;
  logic [WIDTH-1:0]    count;
  logic [WIDTH-1:0]    cur_delay;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req   (i_req),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .index (pick_idx)
  );

  assign cur_delay   = i_delay[int'(cur_idx)*WIDTH +: WIDTH];
  assign next_ptr    = (cur_idx == IDX_W'(NUM_REQ - 1)) ? '0 : cur_idx + 1'b1;
  assign o_remaining = count;

  // The count is only decremented while nonzero, so it can never underflow;
  // an abort clears the grant without ever raising o_done.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= IDLE;
      o_grant <= '0;
      o_done  <= '0;
      o_busy  <= 1'b0;
      count   <= '0;
      rr_ptr  <= '0;
      cur_idx <= '0;
    end else begin
      o_done <= '0;
      case (state)
        IDLE: begin
          if (|i_req) begin
            o_grant <= pick_grant;
            cur_idx <= pick_idx;
            o_busy  <= 1'b1;
            state   <= LOAD;
          end
        end
        LOAD: begin
          count <= cur_delay;
          state <= RUN;
        end
        RUN: begin
          if (!i_req[cur_idx]) begin
            o_grant <= '0;
            o_busy  <= 1'b0;
            state   <= IDLE;
          end else if (count == '0) begin
            o_done <= o_grant;
            state  <= DONE;
          end else if (i_tick) begin
            count <= count - 1'b1;
          end
        end
        DONE: begin
          rr_ptr  <= next_ptr;
          o_grant <= '0;
          o_busy  <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_delay_scheduler.sv
// Self-checking bench for delay_scheduler: directed scenarios plus random traffic
// compared every cycle against a transaction-level reference model.
module tb_delay_scheduler;

  localparam int N = 4;
  localparam int W = 16;

  logic             clock = 1'b0;
  logic             reset;
  logic             tick;
  logic [N-1:0]     req;
  logic [N*W-1:0]   delay;
  logic [N-1:0]     grant;
  logic [N-1:0]     done;
  logic             busy;
  logic [W-1:0]     remaining;

  always #5 clock = ~clock;

  delay_scheduler #(
    .NUM_REQ (N),
    .WIDTH   (W)
  ) dut (
    .i_clk       (clock),
    .i_reset     (reset),
    .i_tick      (tick),
    .i_req       (req),
    .i_delay     (delay),
    .o_grant     (grant),
    .o_done      (done),
    .o_busy      (busy),
    .o_remaining (remaining)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: who owns the counter, whether its delay was captured,
  // the remaining ticks, and which requester is being told it finished.
  int mOwner    = -1;
  int mPtr      = 0;
  int mCount    = 0;
  int mFinished = -1;
  bit mLoaded   = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic setDelay(input int k, input int v);
    delay[k*W +: W] = W'(v);
  endtask

  task automatic modelStep();
    if (reset) begin
      mOwner = -1; mPtr = 0; mCount = 0; mLoaded = 1'b0; mFinished = -1;
    end else if (mFinished >= 0) begin
      mPtr      = (mFinished + 1) % N;
      mOwner    = -1;
      mFinished = -1;
    end else if (mOwner < 0) begin
      for (int off = 0; off < N; off++) begin
        int c = (mPtr + off) % N;
        if (req[c]) begin
          mOwner  = c;
          mLoaded = 1'b0;
          break;
        end
      end
    end else if (!mLoaded) begin
      mCount  = int'(delay[mOwner*W +: W]);
      mLoaded = 1'b1;
    end else if (!req[mOwner]) begin
      mOwner = -1;
    end else if (mCount == 0) begin
      mFinished = mOwner;
    end else if (tick) begin
      mCount--;
    end
  endtask

  task automatic stepCycle();
    logic [31:0] expGrant;
    logic [31:0] expDone;
    @(posedge clock);
    modelStep();
    #1;
    expGrant = (mOwner >= 0) ? (32'd1 << mOwner) : 32'd0;
    expDone  = (mFinished >= 0) ? (32'd1 << mFinished) : 32'd0;
    checkOutput("grant", 32'(grant), expGrant);
    checkOutput("done", 32'(done), expDone);
    checkOutput("busy", 32'(busy), 32'(mOwner >= 0));
    checkOutput("remaining", 32'(remaining), 32'(mCount));
    checkOutput("done_vs_grant", 32'((done != 0) && (done != grant)), 32'd0);
  endtask

  task automatic applyStimulus(input logic rst, input logic tk, input logic [N-1:0] rq);
    reset = rst;
    tick  = tk;
    req   = rq;
  endtask

  task automatic resetDut();
    applyStimulus(1'b1, 1'b0, '0);
    stepCycle();
    stepCycle();
    reset = 1'b0;
  endtask

  int doneAt;
  int busyLowAt;
  int order[$];
  bit found;

  initial begin
    delay = '0;
    applyStimulus(1'b1, 1'b0, '0);
    resetDut();

    // Single request, delay 5: done at T+8, idle at T+9.
    setDelay(1, 5);
    applyStimulus(1'b0, 1'b1, 4'b0010);
    doneAt = -1; busyLowAt = -1;
    for (int k = 0; k < 12; k++) begin
      stepCycle();
      if (k == 0) checkOutput("t1_grant_first", 32'(grant), 32'h2);
      if (done != 0 && doneAt < 0) doneAt = k + 1;
      if (k >= 2 && !busy && busyLowAt < 0) busyLowAt = k + 1;
    end
    checkOutput("t1_done_at", doneAt, 8);
    checkOutput("t1_busy_low_at", busyLowAt, 9);
    resetDut();

    // Contention with all requests held: service order 0,1,2,3,0.
    for (int k = 0; k < N; k++) setDelay(k, k + 2);
    applyStimulus(1'b0, 1'b1, 4'b1111);
    order = {};
    for (int k = 0; k < 200 && order.size() < 5; k++) begin
      stepCycle();
      if (done != 0) order.push_back($clog2(done));
    end
    checkOutput("t2_done_count", order.size(), 5);
    for (int i = 0; i < 5; i++)
      checkOutput($sformatf("t2_order%0d", i), (i < order.size()) ? order[i] : -1, i % N);
    resetDut();

    // Zero delay with tick held low: done at T+3.
    setDelay(0, 0);
    applyStimulus(1'b0, 1'b0, 4'b0001);
    doneAt = -1;
    for (int k = 0; k < 8; k++) begin
      stepCycle();
      if (done != 0 && doneAt < 0) doneAt = k + 1;
    end
    checkOutput("t3_zero_done_at", doneAt, 3);
    resetDut();

    // Delay 3, tick on every 4th cycle (including one ignored in LOAD).
    setDelay(0, 3);
    doneAt = -1;
    for (int k = 0; k < 30 && doneAt < 0; k++) begin
      applyStimulus(1'b0, (k % 4) == 1, 4'b0001);
      stepCycle();
      if (done != 0) doneAt = k + 1;
    end
    checkOutput("t3_gated_done_at", doneAt, 15);
    resetDut();

    // Abort: req2 (delay 10) dropped after 4 ticks; pending req3 is next.
    setDelay(2, 10);
    setDelay(3, 2);
    applyStimulus(1'b0, 1'b1, 4'b1100);
    for (int k = 0; k < 6; k++) stepCycle();
    checkOutput("t4_remaining_before_abort", 32'(remaining), 32'd6);
    req = 4'b1000;
    stepCycle();
    checkOutput("t4_abort_grant", 32'(grant), 32'd0);
    checkOutput("t4_abort_done", 32'(done), 32'd0);
    checkOutput("t4_abort_busy", 32'(busy), 32'd0);
    stepCycle();
    checkOutput("t4_next_grant", 32'(grant), 32'h8);
    for (int k = 0; k < 10; k++) stepCycle();
    resetDut();

    // Reset mid-RUN after the pointer has moved past req0.
    setDelay(1, 1);
    applyStimulus(1'b0, 1'b1, 4'b0010);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      stepCycle();
      if (done != 0) found = 1'b1;
    end
    checkOutput("t5_first_done_seen", 32'(found), 32'd1);
    req = 4'b0000;
    stepCycle();
    setDelay(1, 10);
    req = 4'b0010;
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      stepCycle();
      if (busy && remaining == 16'd7) found = 1'b1;
    end
    checkOutput("t5_reached_7", 32'(found), 32'd1);
    applyStimulus(1'b1, 1'b1, 4'b0010);
    stepCycle();
    checkOutput("t5_reset_grant", 32'(grant), 32'd0);
    checkOutput("t5_reset_busy", 32'(busy), 32'd0);
    checkOutput("t5_reset_remaining", 32'(remaining), 32'd0);
    applyStimulus(1'b0, 1'b1, 4'b1111);
    stepCycle();
    checkOutput("t5_ptr_cleared_grant", 32'(grant), 32'h1);
    resetDut();

    // Delay change during RUN is ignored: delay 6 still done at T+9.
    setDelay(0, 6);
    applyStimulus(1'b0, 1'b1, 4'b0001);
    doneAt = -1;
    for (int k = 0; k < 20 && doneAt < 0; k++) begin
      if (k == 4) setDelay(0, 100);
      stepCycle();
      if (done != 0) doneAt = k + 1;
    end
    checkOutput("t6_done_at", doneAt, 9);
    resetDut();

    // All-ones delay decrements without wrapping.
    setDelay(2, 16'hFFFF);
    applyStimulus(1'b0, 1'b1, 4'b0100);
    for (int k = 0; k < 3; k++) stepCycle();
    checkOutput("all_ones_first_decrement", 32'(remaining), 32'hFFFE);
    resetDut();

    // Random traffic against the reference model.
    for (int k = 0; k < N; k++) setDelay(k, $urandom_range(0, 6));
    for (int cyc = 0; cyc < 3000; cyc++) begin
      reset = ($urandom_range(0, 499) == 0);
      tick  = $urandom_range(0, 1) == 1;
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 11) == 0) req[b] = ~req[b];
      if ($urandom_range(0, 7) == 0) setDelay($urandom_range(0, N - 1), $urandom_range(0, 6));
      stepCycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
